// File: rtl/spi_cmd_decoder.sv
// Decodes SPI byte frames (opcode, address, payload) into 16-bit bus writes and read bursts.
// Strobes are registered one cycle after their trigger; no backpressure, master overruns set err.
module spi_cmd_decoder #(
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs,
  input  logic [7:0]           rx_byte,
  input  logic                 rx_valid,
  output logic [7:0]           tx_byte,
  output logic                 tx_load,
  output logic [ADDR_SIZE-1:0] bus_addr,
  output logic [WORD_SIZE-1:0] bus_wdata,
  output logic                 bus_we,
  output logic                 bus_re,
  input  logic [WORD_SIZE-1:0] bus_rdata,
  input  logic                 bus_rvalid,
  output logic                 err
);

  localparam int AH = ADDR_SIZE - 8;
  localparam logic [ADDR_SIZE-1:0] ADDR_ONE = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE, ADDR_H, ADDR_L, WR_H, WR_L, RD_REQ, RD_WAIT, RD_H, RD_L, DISCARD
  } state_t;

  state_t                state, state_nxt;
  logic [7:0]            tx_byte_nxt;
  logic                  tx_load_nxt;
  logic [ADDR_SIZE-1:0]  addr_nxt;
  logic [WORD_SIZE-1:0]  wdata_nxt;
  logic                  we_nxt, re_nxt, err_nxt;
  logic [AH-1:0]         addr_hi, addr_hi_nxt;
  logic [7:0]            wr_hi, wr_hi_nxt;
  logic [7:0]            rd_lo, rd_lo_nxt;
  logic                  is_read, is_read_nxt;
  logic                  armed, armed_nxt;       // cs seen high since reset
  logic                  clr_pend, clr_pend_nxt; // 0x00 received as the only byte so far
  logic                  rd_out, rd_out_nxt;     // a bus read is awaiting its response

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_byte   <= '0;
      tx_load   <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
      bus_re    <= 1'b0;
      err       <= 1'b0;
      addr_hi   <= '0;
      wr_hi     <= '0;
      rd_lo     <= '0;
      is_read   <= 1'b0;
      armed     <= 1'b0;
      clr_pend  <= 1'b0;
      rd_out    <= 1'b0;
    end else begin
      state     <= state_nxt;
      tx_byte   <= tx_byte_nxt;
      tx_load   <= tx_load_nxt;
      bus_addr  <= addr_nxt;
      bus_wdata <= wdata_nxt;
      bus_we    <= we_nxt;
      bus_re    <= re_nxt;
      err       <= err_nxt;
      addr_hi   <= addr_hi_nxt;
      wr_hi     <= wr_hi_nxt;
      rd_lo     <= rd_lo_nxt;
      is_read   <= is_read_nxt;
      armed     <= armed_nxt;
      clr_pend  <= clr_pend_nxt;
      rd_out    <= rd_out_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    tx_byte_nxt  = tx_byte;
    tx_load_nxt  = 1'b0;
    addr_nxt     = bus_addr;
    wdata_nxt    = bus_wdata;
    we_nxt       = 1'b0;
    re_nxt       = 1'b0;
    err_nxt      = err;
    addr_hi_nxt  = addr_hi;
    wr_hi_nxt    = wr_hi;
    rd_lo_nxt    = rd_lo;
    is_read_nxt  = is_read;
    armed_nxt    = armed;
    clr_pend_nxt = clr_pend;
    rd_out_nxt   = rd_out;

    // Burst address advances once the write strobe has been presented.
    if (bus_we)
      addr_nxt = bus_addr + ADDR_ONE;
    if (bus_rvalid)
      rd_out_nxt = 1'b0;

    if (cs) begin
      state_nxt    = IDLE;
      armed_nxt    = 1'b1;
      clr_pend_nxt = 1'b0;
      if (clr_pend)
        err_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: if (rx_valid && armed) begin
          if (rx_byte == 8'h01 || rx_byte == 8'h02) begin
            is_read_nxt = rx_byte[1];
            state_nxt   = ADDR_H;
          end else begin
            state_nxt = DISCARD;
            if (rx_byte == 8'h00)
              clr_pend_nxt = 1'b1;
            else
              err_nxt = 1'b1;
          end
        end
        ADDR_H: if (rx_valid) begin
          addr_hi_nxt = rx_byte[AH-1:0];
          state_nxt   = ADDR_L;
        end
        ADDR_L: if (rx_valid) begin
          addr_nxt  = {addr_hi, rx_byte};
          state_nxt = is_read ? RD_REQ : WR_H;
        end
        WR_H: if (rx_valid) begin
          wr_hi_nxt = rx_byte;
          state_nxt = WR_L;
        end
        WR_L: if (rx_valid) begin
          wdata_nxt = {wr_hi, rx_byte};
          we_nxt    = 1'b1;
          state_nxt = WR_H;
        end
        RD_REQ: begin
          if (rx_valid)
            err_nxt = 1'b1;
          // Hold off while a response from an aborted frame is still in flight.
          if (!rd_out) begin
            re_nxt     = 1'b1;
            rd_out_nxt = 1'b1;
            state_nxt  = RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rx_valid)
            err_nxt = 1'b1;
          if (bus_rvalid) begin
            tx_byte_nxt = bus_rdata[15:8];
            rd_lo_nxt   = bus_rdata[7:0];
            tx_load_nxt = 1'b1;
            state_nxt   = RD_H;
          end
        end
        RD_H: if (rx_valid) begin
          tx_byte_nxt = rd_lo;
          tx_load_nxt = 1'b1;
          state_nxt   = RD_L;
        end
        RD_L: if (rx_valid) begin
          addr_nxt  = bus_addr + ADDR_ONE;
          state_nxt = RD_REQ;
        end
        DISCARD: if (rx_valid)
          clr_pend_nxt = 1'b0;
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Bench for spi_cmd_decoder: directed frames plus randomized frames checked against a frame-level model.
module tb_spi_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cs = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_load;
  logic [9:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [15:0] bus_rdata = 16'h0000;
  logic        bus_rvalid = 1'b0;
  logic        err;

  int n_checks = 0;
  int n_fail = 0;
  int rd_delay = 3;
  int resp_cnt = 0;
  logic [9:0]  resp_addr = '0;
  logic [15:0] rmem [1024];

  logic [9:0]  we_addr_q[$];
  logic [15:0] we_data_q[$];
  logic [9:0]  re_q[$];
  logic [7:0]  tx_q[$];

  spi_cmd_decoder #(.ADDR_SIZE(10), .WORD_SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_load(tx_load), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .err(err)
  );

  always #5 clk = ~clk;

  // Slave memory model: answers each bus_re after rd_delay cycles.
  always @(negedge clk) begin
    bus_rvalid = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt = resp_cnt - 1;
      if (resp_cnt == 0) begin
        bus_rvalid = 1'b1;
        bus_rdata  = rmem[resp_addr];
      end
    end
    if (bus_re) begin
      resp_cnt  = rd_delay;
      resp_addr = bus_addr;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_we) begin
        we_addr_q.push_back(bus_addr);
        we_data_q.push_back(bus_wdata);
      end
      if (bus_re) re_q.push_back(bus_addr);
      if (tx_load) tx_q.push_back(tx_byte);
      if (bus_we || bus_re) begin
        n_checks++;
        if (bus_we && bus_re) begin
          n_fail++;
          $display("FAIL strobe_exclusive: bus_we=%0b bus_re=%0b, required never both", bus_we, bus_re);
        end
      end
    end
  end

  task automatic clear_queues();
    we_addr_q.delete(); we_data_q.delete(); re_q.delete(); tx_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    rx_byte = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic end_frame();
    @(posedge clk); #1 cs = 1'b1;
    repeat (3) @(posedge clk);
    #1 cs = 1'b0;
  endtask

  task automatic wait_tx(input int target);
    int t;
    t = 0;
    while (tx_q.size() < target && t < 200) begin
      @(posedge clk);
      t++;
    end
    n_checks++;
    if (tx_q.size() < target) begin
      n_fail++;
      $display("FAIL wait_tx: got %0d tx_load strobes, required %0d", tx_q.size(), target);
    end
  endtask

  task automatic run_read(input logic [7:0] ah, input logic [7:0] al, input int nwords);
    int base;
    base = tx_q.size();
    send_byte(8'h02, 0); send_byte(ah, 0); send_byte(al, 0);
    for (int w = 0; w < nwords; w++) begin
      wait_tx(base + 2*w + 1);
      send_byte(8'($urandom), 0);
      wait_tx(base + 2*w + 2);
      if (w < nwords - 1) send_byte(8'($urandom), 0);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte: got %h, required 00", tx_byte); end
    if (tx_load !== 1'b0) begin n_fail++; $display("FAIL reset_tx_load: got %b, required 0", tx_load); end
    if (bus_addr !== 10'h000) begin n_fail++; $display("FAIL reset_bus_addr: got %h, required 000", bus_addr); end
    if (bus_wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_bus_wdata: got %h, required 0000", bus_wdata); end
    if (bus_we !== 1'b0 || bus_re !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got we=%b re=%b, required 0 0", bus_we, bus_re); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", err); end
    n_checks += 6;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 cs = 1'b0;
  endtask

  task automatic test_write_single();
    clear_queues();
    send_byte(8'h01, 0); send_byte(8'h00, 1); send_byte(8'h10, 0);
    send_byte(8'hAB, 2); send_byte(8'hCD, 0);
    end_frame();
    n_checks++;
    if (we_addr_q.size() !== 1) begin
      n_fail++; $display("FAIL write_single_count: got %0d writes, required 1", we_addr_q.size());
    end else begin
      n_checks++;
      if (we_addr_q[0] !== 10'h010 || we_data_q[0] !== 16'hABCD) begin
        n_fail++; $display("FAIL write_single: got %h@%h, required abcd@010", we_data_q[0], we_addr_q[0]);
      end
    end
  endtask

  task automatic test_write_burst_wrap();
    logic [9:0]  ea[2];
    logic [15:0] ed[2];
    ea[0] = 10'h3FF; ed[0] = 16'h1122;
    ea[1] = 10'h000; ed[1] = 16'h3344;
    clear_queues();
    send_byte(8'h01, 0); send_byte(8'h03, 0); send_byte(8'hFF, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    end_frame();
    n_checks++;
    if (we_addr_q.size() !== 2) begin
      n_fail++; $display("FAIL burst_count: got %0d writes, required 2", we_addr_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++;
        if (we_addr_q[i] !== ea[i] || we_data_q[i] !== ed[i]) begin
          n_fail++; $display("FAIL burst_word%0d: got %h@%h, required %h@%h", i, we_data_q[i], we_addr_q[i], ed[i], ea[i]);
        end
      end
    end
  endtask

  task automatic test_read_directed();
    clear_queues();
    rd_delay = 3;
    rmem[10'h005] = 16'hBEEF;
    run_read(8'h00, 8'h05, 1);
    send_byte(8'h5A, 0);
    repeat (3) @(posedge clk);
    end_frame();
    repeat (8) @(posedge clk);
    n_checks++;
    if (tx_q.size() !== 2) begin
      n_fail++; $display("FAIL read_tx_count: got %0d tx_load strobes, required 2", tx_q.size());
    end else begin
      n_checks++;
      if (tx_q[0] !== 8'hBE || tx_q[1] !== 8'hEF) begin
        n_fail++; $display("FAIL read_tx_bytes: got %h %h, required be ef", tx_q[0], tx_q[1]);
      end
    end
    n_checks++;
    if (re_q.size() !== 2) begin
      n_fail++; $display("FAIL read_re_count: got %0d bus_re, required 2", re_q.size());
    end else begin
      n_checks++;
      if (re_q[0] !== 10'h005 || re_q[1] !== 10'h006) begin
        n_fail++; $display("FAIL read_re_addr: got %h %h, required 005 006", re_q[0], re_q[1]);
      end
    end
  endtask

  task automatic test_abort_write();
    clear_queues();
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h20, 0); send_byte(8'hAA, 0);
    end_frame();
    n_checks += 2;
    if (we_addr_q.size() !== 0) begin n_fail++; $display("FAIL abort_no_we: got %0d writes, required 0", we_addr_q.size()); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL abort_err: got %b, required 0", err); end
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h21, 0); send_byte(8'h5A, 0); send_byte(8'hA5, 0);
    end_frame();
    n_checks++;
    if (we_addr_q.size() !== 1 || we_addr_q[0] !== 10'h021 || we_data_q[0] !== 16'h5AA5) begin
      n_fail++; $display("FAIL abort_then_idle: got %0d writes, required one 5aa5@021", we_addr_q.size());
    end
  endtask

  task automatic test_invalid_opcode();
    logic [7:0] bytes[6];
    bytes = '{8'h7F, 8'h01, 8'h00, 8'h10, 8'hAB, 8'hCD};
    clear_queues();
    foreach (bytes[i]) send_byte(bytes[i], 0);
    end_frame();
    n_checks += 2;
    if (err !== 1'b1) begin n_fail++; $display("FAIL invalid_err_set: got %b, required 1", err); end
    if (we_addr_q.size() + re_q.size() + tx_q.size() !== 0) begin
      n_fail++; $display("FAIL invalid_no_strobes: got %0d strobes, required 0", we_addr_q.size() + re_q.size() + tx_q.size());
    end
    send_byte(8'h00, 0);
    end_frame();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL clear_cmd: got err %b, required 0", err); end
  endtask

  task automatic test_overrun();
    clear_queues();
    rd_delay = 6;
    rmem[10'h040] = 16'hC35A;
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h40, 0);
    send_byte(8'h55, 0);
    wait_tx(1);
    send_byte(8'h00, 0);
    wait_tx(2);
    end_frame();
    n_checks += 3;
    if (err !== 1'b1) begin n_fail++; $display("FAIL overrun_err: got %b, required 1", err); end
    if (re_q.size() !== 1) begin n_fail++; $display("FAIL overrun_re_count: got %0d, required 1", re_q.size()); end
    if (tx_q.size() !== 2 || tx_q[0] !== 8'hC3 || tx_q[1] !== 8'h5A) begin
      n_fail++; $display("FAIL overrun_tx: got %0d bytes, required c3 5a", tx_q.size());
    end
    send_byte(8'h00, 0);
    end_frame();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got err %b, required 0", err); end
  endtask

  task automatic test_random_frames();
    logic [9:0]  exp_wa[$];
    logic [15:0] exp_wd[$];
    logic [9:0]  exp_re[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  pl[8];
    logic [7:0]  ah, al;
    logic        exp_err;
    int kind, len, nw, a;
    exp_err = 1'b0;
    for (int f = 0; f < 24; f++) begin
      clear_queues();
      exp_wa.delete(); exp_wd.delete(); exp_re.delete(); exp_tx.delete();
      kind = $urandom_range(0, 9);
      ah = 8'($urandom); al = 8'($urandom);
      a = {ah[1:0], al};
      rd_delay = $urandom_range(1, 4);
      if (kind < 4) begin
        len = $urandom_range(0, 7);
        send_byte(8'h01, $urandom_range(0, 2)); send_byte(ah, 0); send_byte(al, $urandom_range(0, 2));
        for (int i = 0; i < len; i++) begin
          pl[i] = 8'($urandom);
          send_byte(pl[i], $urandom_range(0, 2));
        end
        for (int w = 0; w < len / 2; w++) begin
          exp_wa.push_back(10'((a + w) % 1024));
          exp_wd.push_back({pl[2*w], pl[2*w+1]});
        end
      end else if (kind < 7) begin
        nw = $urandom_range(1, 3);
        run_read(ah, al, nw);
        for (int w = 0; w < nw; w++) begin
          exp_re.push_back(10'((a + w) % 1024));
          exp_tx.push_back(rmem[(a + w) % 1024][15:8]);
          exp_tx.push_back(rmem[(a + w) % 1024][7:0]);
        end
      end else if (kind < 9) begin
        send_byte(8'($urandom_range(3, 255)), 0);
        len = $urandom_range(0, 4);
        for (int i = 0; i < len; i++) send_byte(8'($urandom), 0);
        exp_err = 1'b1;
      end else begin
        send_byte(8'h00, 0);
        exp_err = 1'b0;
      end
      end_frame();
      n_checks += 4;
      if (we_addr_q.size() !== exp_wa.size()) begin n_fail++; $display("FAIL rnd%0d_we_count: got %0d, required %0d", f, we_addr_q.size(), exp_wa.size()); end
      if (re_q.size() !== exp_re.size()) begin n_fail++; $display("FAIL rnd%0d_re_count: got %0d, required %0d", f, re_q.size(), exp_re.size()); end
      if (tx_q.size() !== exp_tx.size()) begin n_fail++; $display("FAIL rnd%0d_tx_count: got %0d, required %0d", f, tx_q.size(), exp_tx.size()); end
      if (err !== exp_err) begin n_fail++; $display("FAIL rnd%0d_err: got %b, required %b", f, err, exp_err); end
      for (int i = 0; i < exp_wa.size() && i < we_addr_q.size(); i++) begin
        n_checks++;
        if (we_addr_q[i] !== exp_wa[i] || we_data_q[i] !== exp_wd[i]) begin
          n_fail++; $display("FAIL rnd%0d_write%0d: got %h@%h, required %h@%h", f, i, we_data_q[i], we_addr_q[i], exp_wd[i], exp_wa[i]);
        end
      end
      for (int i = 0; i < exp_re.size() && i < re_q.size(); i++) begin
        n_checks++;
        if (re_q[i] !== exp_re[i]) begin n_fail++; $display("FAIL rnd%0d_re%0d: got %h, required %h", f, i, re_q[i], exp_re[i]); end
      end
      for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++) begin
        n_checks++;
        if (tx_q[i] !== exp_tx[i]) begin n_fail++; $display("FAIL rnd%0d_tx%0d: got %h, required %h", f, i, tx_q[i], exp_tx[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    send_byte(8'h7F, 0);
    end_frame();
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_err: got %b, required 1", err); end
    clear_queues();
    rd_delay = 5;
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h07, 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (bus_re !== 1'b0 || bus_we !== 1'b0 || tx_load !== 1'b0) begin
      n_fail++; $display("FAIL midrst_strobes: got re=%b we=%b load=%b, required 0 0 0", bus_re, bus_we, tx_load);
    end
    if (bus_addr !== 10'h000) begin n_fail++; $display("FAIL midrst_addr: got %h, required 000", bus_addr); end
    if (tx_byte !== 8'h00 || bus_wdata !== 16'h0000) begin
      n_fail++; $display("FAIL midrst_data: got tx %h wdata %h, required 00 0000", tx_byte, bus_wdata);
    end
    if (err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b, required 0", err); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_queues();
    repeat (8) @(posedge clk);
    n_checks++;
    if (tx_q.size() !== 0) begin n_fail++; $display("FAIL midrst_late_rvalid: got %0d tx_load, required 0", tx_q.size()); end
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h30, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
    repeat (2) @(posedge clk);
    n_checks++;
    if (we_addr_q.size() !== 0) begin n_fail++; $display("FAIL midrst_unarmed: got %0d writes, required 0", we_addr_q.size()); end
    end_frame();
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h30, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
    end_frame();
    n_checks++;
    if (we_addr_q.size() !== 1 || we_addr_q[0] !== 10'h030 || we_data_q[0] !== 16'h1234) begin
      n_fail++; $display("FAIL midrst_rearmed: got %0d writes, required one 1234@030", we_addr_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rmem[i] = 16'($urandom);
    test_reset();
    test_write_single();
    test_write_burst_wrap();
    test_read_directed();
    test_abort_write();
    test_invalid_opcode();
    test_overrun();
    test_random_frames();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
